// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM with duty sets double-buffered to period boundaries and optional phase stagger.
// Outputs are registered one clk after the counter value they reflect and advance only on tick.
module pwm_multi_gen #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  input  logic                      stagger_in,
  output logic                      load_ack,
  output logic                      period_end,
  output logic [CHANNELS-1:0]       pwm_out
);
  localparam int               OFS     = (1 << WIDTH) / CHANNELS;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]                 cnt;
  logic [CHANNELS-1:0][WIDTH-1:0]   act_duty;
  logic [CHANNELS-1:0][WIDTH-1:0]   pend_duty;
  logic                             pend_valid;
  logic                             act_stagger;
  logic                             pend_stagger;
  logic [CHANNELS-1:0]              pwm_nxt;
  logic                             wrap;

  assign wrap = tick && (cnt == CNT_MAX);

  // Each channel sees the shared counter shifted by its own slice of the period.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [WIDTH-1:0] PH_OFS = WIDTH'(g * OFS);
    logic [WIDTH-1:0] ph;
    assign ph         = act_stagger ? cnt + PH_OFS : cnt;
    assign pwm_nxt[g] = ph < act_duty[g];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= '0;
      act_duty     <= '0;
      pend_duty    <= '0;
      pend_valid   <= 1'b0;
      act_stagger  <= 1'b0;
      pend_stagger <= 1'b0;
      pwm_out      <= '0;
      load_ack     <= 1'b0;
      period_end   <= 1'b0;
    end else begin
      load_ack   <= load;
      period_end <= wrap;
      if (tick) begin
        cnt     <= cnt + 1'b1;
        pwm_out <= pwm_nxt;
      end
      // Boundary promotion reads pending as it stood before a same-cycle load overwrites it.
      if (wrap && pend_valid) begin
        act_duty    <= pend_duty;
        act_stagger <= pend_stagger;
      end
      if (load) begin
        pend_duty    <= duty_in;
        pend_stagger <= stagger_in;
        pend_valid   <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: a cycle model queues expected outputs, plus per-period measurements.
module tb_pwm_multi_gen;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset, tick, load, stagger_in;
  logic [N*W-1:0] duty_in;
  logic           load_ack, period_end;
  logic [N-1:0]   pwm_out;

  always #5 clk = ~clk;

  pwm_multi_gen #(.CHANNELS(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .duty_in(duty_in), .load(load),
    .stagger_in(stagger_in), .load_ack(load_ack), .period_end(period_end), .pwm_out(pwm_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0]   m_cnt;
  logic [7:0]   m_act[N];
  logic [7:0]   m_pend[N];
  logic         m_pv, m_act_st, m_pend_st, m_ack, m_pe;
  logic [N-1:0] m_pwm;
  logic [N+1:0] exp_q[$];

  // Measurement state
  int           hi[N], last_hi[N], rise_at[N];
  int           periods = 0, win_cyc = 0, last_win_cyc = 0;
  int           overlap = 0, ack_cnt = 0, pe_cnt = 0, rises_off0 = 0, any_hi = 0;
  logic [N-1:0] prev_pwm = '0;
  logic         tgl = 1'b1;

  task automatic cyc(input logic rst_n, input logic tk, input logic ld,
                     input logic [N*W-1:0] din, input logic st);
    logic [7:0]   base, ph;
    logic         wrp;
    logic [N+1:0] e, got;
    reset = rst_n; tick = tk; load = ld; duty_in = din; stagger_in = st;
    base = m_cnt;
    if (!rst_n) begin
      m_cnt = '0; m_pv = 0; m_act_st = 0; m_pend_st = 0; m_ack = 0; m_pe = 0; m_pwm = '0;
      for (int i = 0; i < N; i++) begin m_act[i] = '0; m_pend[i] = '0; end
    end else begin
      wrp   = tk && (m_cnt == 8'hFF);
      m_ack = ld;
      m_pe  = wrp;
      if (tk)
        for (int i = 0; i < N; i++) begin
          ph = m_act_st ? m_cnt + 8'(i * 64) : m_cnt;
          m_pwm[i] = ph < m_act[i];
        end
      if (wrp && m_pv) begin
        for (int i = 0; i < N; i++) m_act[i] = m_pend[i];
        m_act_st = m_pend_st;
        m_pv = 0;
      end
      if (ld) begin
        for (int i = 0; i < N; i++) m_pend[i] = din[i*W +: W];
        m_pend_st = st;
        m_pv = 1;
      end
      if (tk) m_cnt = m_cnt + 8'd1;
    end
    exp_q.push_back({m_pwm, m_ack, m_pe});
    @(posedge clk); #1;
    e   = exp_q.pop_front();
    got = {pwm_out, load_ack, period_end};
    chk("cycle", 32'(got), 32'(e));
    ack_cnt += int'(load_ack);
    pe_cnt  += int'(period_end);
    if (pwm_out != '0) any_hi++;
    if (!rst_n) begin
      hi = '{default: 0};
      win_cyc = 0;
    end else begin
      win_cyc++;
      for (int i = 0; i < N; i++) begin
        hi[i] += int'(pwm_out[i]);
        if (pwm_out[i] && !prev_pwm[i]) begin
          rise_at[i] = int'(base);
          if (base != 8'd0) rises_off0++;
        end
      end
      if ($countones(pwm_out) > 1) overlap++;
      if (tk && base == 8'hFF) begin
        last_hi = hi;
        hi = '{default: 0};
        last_win_cyc = win_cyc;
        win_cyc = 0;
        periods++;
      end
    end
    prev_pwm = pwm_out;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic do_load(input logic [N*W-1:0] din, input logic st);
    cyc(1'b1, 1'b1, 1'b1, din, st);
  endtask

  task automatic run_to_wrap(input logic toggle);
    int p0 = periods;
    int k  = 0;
    while (periods == p0 && k < 1200) begin
      cyc(1'b1, toggle ? tgl : 1'b1, 1'b0, '0, 1'b0);
      tgl = ~tgl;
      k++;
    end
    chk("wrap_reached", 32'(periods), 32'(p0 + 1));
  endtask

  task automatic run_until_cnt(input logic [7:0] v);
    int k = 0;
    while (m_cnt != v && k < 600) begin
      idle(1);
      k++;
    end
  endtask

  int first_pe;
  int exp_basic[N] = '{0, 1, 128, 255};

  initial begin
    m_cnt = '0; m_pv = 0; m_act_st = 0; m_pend_st = 0; m_ack = 0; m_pe = 0; m_pwm = '0;
    for (int i = 0; i < N; i++) begin
      m_act[i] = '0; m_pend[i] = '0; hi[i] = 0; last_hi[i] = 0; rise_at[i] = -1;
    end

    // Reset dominates load and tick; then one idle period of exactly 256 ticks.
    repeat (3) cyc(1'b0, 1'b1, 1'b1, {N{8'hA5}}, 1'b1);
    first_pe = -1;
    any_hi = 0;
    for (int k = 1; k <= 258; k++) begin
      idle(1);
      if (period_end && first_pe < 0) first_pe = k;
    end
    chk("first_wrap", 32'(first_pe), 32'd256);
    chk("idle_activity", 32'(any_hi), 32'd0);

    // Basic duties, activated only at the first boundary.
    ack_cnt = 0;
    do_load({8'hFF, 8'h80, 8'h01, 8'h00}, 1'b0);
    run_to_wrap(1'b0);
    rises_off0 = 0;
    for (int p = 0; p < 2; p++) begin
      run_to_wrap(1'b0);
      for (int i = 0; i < N; i++)
        chk($sformatf("basic_hi_p%0d_ch%0d", p, i), 32'(last_hi[i]), 32'(exp_basic[i]));
    end
    chk("basic_ack_pulses", 32'(ack_cnt), 32'd1);
    chk("basic_rise_off_cnt0", 32'(rises_off0), 32'd0);

    // Double buffering: last load before the boundary wins.
    idle(16);
    do_load({8'hFF, 8'h80, 8'h01, 8'h40}, 1'b0);
    do_load({8'hFF, 8'h80, 8'h01, 8'h20}, 1'b0);
    run_to_wrap(1'b0);
    chk("dbuf_old_period", 32'(last_hi[0]), 32'd0);
    run_to_wrap(1'b0);
    chk("dbuf_new_period", 32'(last_hi[0]), 32'd32);

    // Load coinciding with the wrap.
    idle(5);
    do_load({8'hFF, 8'h80, 8'h01, 8'h10}, 1'b0);
    run_until_cnt(8'hFF);
    pe_cnt = 0;
    do_load({8'hFF, 8'h80, 8'h01, 8'h30}, 1'b0);
    run_to_wrap(1'b0);
    chk("simul_first", 32'(last_hi[0]), 32'h10);
    chk("simul_pe_pulses", 32'(pe_cnt), 32'd2);
    run_to_wrap(1'b0);
    chk("simul_second", 32'(last_hi[0]), 32'h30);

    // Phase stagger.
    do_load({N{8'h40}}, 1'b1);
    run_to_wrap(1'b0);
    rise_at = '{default: -1};
    overlap = 0;
    run_to_wrap(1'b0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("stag_hi_ch%0d", i), 32'(last_hi[i]), 32'd64);
      chk($sformatf("stag_rise_ch%0d", i), 32'(rise_at[i]), 32'((256 - 64 * i) % 256));
    end
    chk("stag_overlap", 32'(overlap), 32'd0);

    // Tick gating halves the rate without changing the ratio.
    tgl = 1'b1;
    run_to_wrap(1'b1);
    run_to_wrap(1'b1);
    chk("tick_period_clks", 32'(last_win_cyc), 32'd512);
    for (int i = 0; i < N; i++)
      chk($sformatf("tick_hi_ch%0d", i), 32'(last_hi[i]), 32'd128);

    // Reset mid-period discards pending and active sets.
    do_load({N{8'h99}}, 1'b0);
    run_until_cnt(8'h77);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("midrst_pwm", 32'(pwm_out), 32'd0);
    run_to_wrap(1'b0);
    run_to_wrap(1'b0);
    for (int i = 0; i < N; i++)
      chk($sformatf("midrst_discard_ch%0d", i), 32'(last_hi[i]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator for the lamp datapath. It replaces the fixed 4×8-bit PWM stage and drives one output per LED channel. Duty values are double-buffered: software loads a pending set at any time, and the set becomes active only at a period boundary, so a period never glitches. It also adds an optional phase-stagger mode that spreads channel turn-on edges across the period to reduce peak supply current.

Parameters:
CHANNELS, 4, number of PWM channels; power of two, 1..2^WIDTH
WIDTH, 8, duty and counter width; PWM period = 2^WIDTH ticks

Ports:
clk  in  1  system clock (the shared divided system clock)
reset  in  1  synchronous, active-low reset
tick  in  1  prescaler enable; the counter advances only in cycles where tick=1
duty_in  in  CHANNELS*WIDTH  duty set; channel i occupies bits [i*WIDTH +: WIDTH]
load  in  1  single-cycle strobe; captures duty_in and stagger_in into the pending set
stagger_in  in  1  requested phase-stagger mode, captured together with load
load_ack  out  1  one-cycle pulse in the cycle after a load is captured
period_end  out  1  one-cycle pulse in the cycle after the counter wraps
pwm_out  out  CHANNELS  registered PWM outputs

Behaviour:
- Reset is sampled on the clk rising edge while reset=0. It clears:
  - the counter cnt
  - all active and pending duties
  - pending_valid
  - active and pending stagger
  - pwm_out, load_ack and period_end, all to 0
- Reset has priority over every other input, including mid-period and mid-load.
- Counter:
  - cnt is WIDTH bits and increments by 1 on each cycle with tick=1.
  - It wraps from 2^WIDTH-1 to 0. With tick=0, cnt holds.
- Boundary event: tick=1 and cnt=2^WIDTH-1.
  - period_end is 1 in the following cycle only.
  - If pending_valid=1: active duties and active stagger take the pending set, and pending_valid clears.
  - If pending_valid=0: active values are unchanged.
- Load:
  - When load=1, duty_in and stagger_in go into the pending registers and pending_valid is set.
  - load_ack=1 in the next cycle.
  - Back-to-back loads overwrite pending; the last load before a boundary wins.
  - Load capture is independent of tick.
- Load and boundary in the same cycle:
  - active takes the pending contents as they were before that edge, if pending was valid.
  - The new load lands in pending with pending_valid=1 and applies at the next boundary.
- Phase per channel:
  - Base offset is OFS = 2^WIDTH / CHANNELS.
  - With active stagger=1, ph_i = (cnt + i*OFS) mod 2^WIDTH.
  - With active stagger=0, ph_i = cnt.
- Output:
  - pwm_out[i] is registered as (ph_i < active_duty_i), one clk after the cnt value it is based on.
  - With tick=0, pwm_out holds its value.
- Duty boundaries:
  - duty=0 gives a constantly low output.
  - duty=2^WIDTH-1 is high for 2^WIDTH-1 of 2^WIDTH ticks; 100% duty is not reachable by design.
  - The high time per period equals the duty exactly, for every value, in both modes.
- Arithmetic:
  - All phase additions are WIDTH-bit modulo; there is no saturation.
  - Comparison is unsigned.
- CHANNELS=1: stagger has no effect (OFS·0=0).

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles with load=1 and tick=1, then release. Required: pwm_out=0, load_ack=0, period_end=0; the first wrap occurs after exactly 256 ticks (W=8) with no output activity.
- Basic duty: load ch0..3 = 0x00, 0x01, 0x80, 0xFF, stagger=0; run 2 full periods with tick=1. Required:
  - load_ack pulses once.
  - The new set is active only from the first boundary.
  - High counts per period are 0, 1, 128, 255.
  - All rising edges occur at cnt=0 (+1 clk latency).
- Double-buffer / last-wins: mid-period, load 0x40 then 0x20 on ch0. Required: ch0 stays at its old duty until the wrap, then runs 32 high ticks; no partial period.
- Simultaneous load and boundary: pending holds A=0x10; load B=0x30 exactly on the wrap cycle. Required: the next period uses 0x10, the following period uses 0x30, and period_end pulses on both wraps.
- Stagger: load all channels 0x40 with stagger=1 (N=4, W=8). Required: ch i rises at cnt = (256 - 64i) mod 256, i.e. 0, 192, 128, 64. Each channel stays high for 64 ticks, and at most one channel is high at any cnt.
- Tick gating and mid-operation reset:
  - With tick toggling 1/0, the period is 512 clk and the duty ratios are unchanged.
  - Asserting reset at cnt=0x77 zeroes all outputs on the next edge and discards pending.
